muldiv_unit: RTL and testbench

Multi-cycle integer multiply/divide unit that owns the HI/LO special registers of the single-cycle MIPS core. It sits directly downstream of the main decoder and consumes the R-type `funct` field and the `spregwrite`/`mf` controls. It also provides a stall so that the single-cycle datapath freezes while an iterative operation is in flight.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_unit_div_step.sv | 24 ++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 tb/tb_muldiv_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states,
// decoded R-type funct codes and the iteration count of the serial datapath.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  localparam int ITERS = 32;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when the shifted partial remainder is large enough.
module div_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic             qbit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem, dbit};
  assign diff    = shifted - {1'b0, divisor};
  // A shifted value at or above 2^WIDTH always exceeds any divisor.
  assign qbit     = shifted[WIDTH] | ~diff[WIDTH];
  assign rem_next = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO, with a stall for the core.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply, division unchanged.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic             mf_req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  state_t               state, state_next;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb, a_raw;
  logic                 op_div, a_neg, b_neg, b_zero;
  logic                 is_mul, is_div, is_signed, accept;
  logic [WIDTH-1:0]     amag, bmag, rem_next, res_hi, res_lo;
  logic                 qbit;
  logic [WIDTH:0]       mul_sum;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                 input logic sgn);
    return (sgn && x < 0) ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  assign is_mul    = (funct == F_MULT) || (funct == F_MULTU);
  assign is_div    = (funct == F_DIV)  || (funct == F_DIVU);
  assign is_signed = (funct == F_MULT) || (funct == F_DIV);
  assign accept    = (state == IDLE) && start && (is_mul || is_div);
  assign amag      = magnitude(a, is_signed);
  assign bmag      = magnitude(b, is_signed);
  assign busy      = (state != IDLE);
  assign stall     = busy & (start | mf_req);

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (acc[2*WIDTH-1:WIDTH]),
    .dbit     (acc[WIDTH-1]),
    .divisor  (opb),
    .rem_next (rem_next),
    .qbit     (qbit)
  );

  // Shift-add: the multiplier sits in the low half and is consumed LSB first.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
          state_next = is_mul ? FIXUP : CALC;
`else
          state_next = CALC;
`endif
        end
      end
      CALC:    if (cnt == 6'(ITERS - 1)) state_next = FIXUP;
      FIXUP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (op_div) begin
      if (b_zero) begin
        res_hi = a_raw;
        res_lo = '1;
      end else begin
        res_lo = neg_w(acc[WIDTH-1:0], a_neg ^ b_neg);
        res_hi = neg_w(acc[2*WIDTH-1:WIDTH], a_neg);
      end
    end else begin
      {res_hi, res_lo} = neg_d(acc, a_neg ^ b_neg);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state == CALC) ? cnt + 6'd1 : 6'd0;
      if (state == FIXUP) begin
        hi <= res_hi;
        lo <= res_lo;
      end else if (state == IDLE && start) begin
        if (funct == F_MTHI) hi <= a;
        if (funct == F_MTLO) lo <= a;
      end
    end
  end

  // Operand latch at acceptance, then one iteration per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      opb       <= bmag;
      a_raw     <= a;
      op_div    <= is_div;
      a_neg     <= is_signed & a[WIDTH-1];
      b_neg     <= is_signed & b[WIDTH-1];
      b_zero    <= (b == '0);
`ifdef MULDIV_FAST_MUL_EN
      acc <= is_mul ? ({{WIDTH{1'b0}}, amag} * {{WIDTH{1'b0}}, bmag})
                    : {{WIDTH{1'b0}}, amag};
`else
      acc <= {{WIDTH{1'b0}}, amag};
`endif
    end else if (state == CALC) begin
      if (op_div) acc <= {rem_next, acc[WIDTH-2:0], qbit};
      else        acc <= {mul_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: random and directed ops against a
// 64-bit arithmetic reference model; a monitor checks HI/LO on completion.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, mf_req;
  logic [5:0]   funct;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, stall;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct), .mf_req(mf_req),
    .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] hi_vis = '0;
  logic [W-1:0] lo_vis = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t r;
    longint sx, sy, q, rm;
    longint unsigned ux, uy, uq, ur;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    r.hi = '0;
    r.lo = '0;
    case (f)
      F_MULT:  begin q = sx * sy; r.hi = q[63:32]; r.lo = q[31:0]; end
      F_MULTU: begin uq = ux * uy; r.hi = uq[63:32]; r.lo = uq[31:0]; end
      F_DIV, F_DIVU: begin
        if (y == '0) begin
          r.hi = x;
          r.lo = '1;
        end else if (f == F_DIV) begin
          q = sx / sy; rm = sx % sy;
          r.lo = q[31:0]; r.hi = rm[31:0];
        end else begin
          uq = ux / uy; ur = ux % uy;
          r.lo = uq[31:0]; r.hi = ur[31:0];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  function automatic bit is_muldiv(input logic [5:0] f);
    return f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU;
  endfunction

  function automatic int latency(input logic [5:0] f);
`ifdef MULDIV_FAST_MUL_EN
    if (f == F_MULT || f == F_MULTU) return 1;
`endif
    return 33;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Completion monitor: a falling busy means HI/LO now carry a result.
  initial begin
    logic bq;
    exp_t e;
    bq = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        bq = 1'b0;
      end else begin
        if (bq && !busy) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL done_without_op: got completion expected none");
          end else begin
            e = sb.pop_front();
            check("result_hi", hi, e.hi);
            check("result_lo", lo, e.lo);
            hi_vis = e.hi;
            lo_vis = e.lo;
          end
        end
        bq = busy;
      end
    end
  end

  // Samples from the next negedge until busy is low; stall and held HI/LO are checked meanwhile.
  task automatic hold(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      check({tag, "_stall"}, stall, 1);
      check({tag, "_hi_held"}, hi, hi_vis);
      check({tag, "_lo_held"}, lo, lo_vis);
      n++;
      @(negedge clk);
    end
    if (n >= 100) check({tag, "_busy_timeout"}, busy, 0);
  endtask

  task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit wait_done, input bit sync, input string tag);
    exp_t e;
    int   n;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    funct = f; a = x; b = y; start = 1'b1;
    hold(tag);
    check({tag, "_stall_at_issue"}, stall, 0);
    if (is_muldiv(f)) begin
      e = model(f, x, y);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom; funct = 6'($urandom);
    if (f == F_MTHI || f == F_MTLO) begin
      @(negedge clk);
      check({tag, "_mt_busy"}, busy, 0);
      if (f == F_MTHI) begin hi_vis = x; check({tag, "_mthi"}, hi, x); end
      else             begin lo_vis = x; check({tag, "_mtlo"}, lo, x); end
    end else if (!is_muldiv(f)) begin
      @(negedge clk);
      check({tag, "_ign_busy"}, busy, 0);
      check({tag, "_ign_hi"}, hi, hi_vis);
      check({tag, "_ign_lo"}, lo, lo_vis);
    end else if (wait_done) begin
      n = 0;
      @(negedge clk);
      while (busy === 1'b1 && n < 200) begin
        n++;
        @(negedge clk);
      end
      check({tag, "_busy_cycles"}, n, latency(f));
    end
  endtask

  initial begin
    logic [5:0] fl [7];
    int n;
    fl = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, 6'b100000};
    reset = 1'b0; start = 1'b0; mf_req = 1'b0; funct = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    reset = 1'b1;

    issue(F_MTHI,  32'h0000_1234, 32'h0, 1, 1, "mthi");
    issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, "multu_max");
    issue(F_MULT,  32'hFFFF_FFFD, 32'd7, 1, 1, "mult_neg");
    issue(F_DIV,   32'hFFFF_FFF9, 32'd2, 1, 1, "div_neg");
    issue(F_DIVU,  32'd100, 32'd0, 1, 1, "divu_zero");
    issue(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1, 1, "div_ovf");
    issue(F_DIV,   32'hFFFF_FF00, 32'd0, 1, 1, "div_zero_neg");
    issue(F_MTLO,  32'hCAFE_0001, 32'h0, 1, 1, "mtlo");

    // mf during a divide, then back-to-back ops held off by the stall.
    issue(F_DIVU, 32'd1000, 32'd7, 0, 1, "div_bg");
    mf_req = 1'b1;
    hold("mf");
    check("mf_stall_released", stall, 0);
    mf_req = 1'b0;
    issue(F_MULT, 32'h8000_0000, 32'h8000_0000, 0, 1, "mult_bg");
    issue(F_MTHI, 32'h0BAD_F00D, 32'h0, 1, 1, "mthi_after_busy");

    for (int i = 0; i < 40; i++) begin
      issue(fl[$urandom_range(0, 6)], pick(), pick(), bit'($urandom_range(0, 1)), 1, "rand");
    end
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    @(negedge clk);
    check("drain_sb_empty", sb.size(), 0);

    // Asynchronous abort partway through a divide.
    issue(F_DIV, 32'h1234_5678, 32'd3, 0, 1, "div_abort");
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    check("abort_stall", stall, 0);
    sb.delete();
    hi_vis = '0;
    lo_vis = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    issue(F_DIVU, 32'd9, 32'd4, 1, 0, "divu_after_rst");
    @(negedge clk);
    check("final_hi", hi, 32'd1);
    check("final_lo", lo, 32'd2);
    check("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
